// File: rtl/uop_result_collector_if.sv
// Handshake and result bus between the micro-op result collector and its harness.
// The master drives run control, issue requests and the wrapper's dst word; the slave is the collector.
interface uop_result_collector_if #(
  parameter int W     = 64,
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [CNT_W-1:0] num_i;
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [W-1:0]     dst_i;
  logic             res_valid_o;
  logic [W-1:0]     res_data_o;
  logic [W-1:0]     sig_o;
  logic [CNT_W-1:0] count_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, num_i, issue_valid_i, dst_i,
    input  issue_ready_o, res_valid_o, res_data_o, sig_o, count_o, busy_o, done_o
  );

  modport slave (
    input  start_i, num_i, issue_valid_i, dst_i,
    output issue_ready_o, res_valid_o, res_data_o, sig_o, count_o, busy_o, done_o
  );
endinterface

// File: rtl/uop_result_collector.sv
// Supplies the missing valid for the micro-op wrapper: a delay line matched to its latency marks real
// results, which are counted against a programmed target and folded into a rotate-XOR signature.
module uop_result_collector #(
  parameter int          W        = 64,
  parameter int          LAT      = 3,
  parameter int          CNT_W    = 16,
  parameter logic [63:0] SIG_SEED = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  uop_result_collector_if.slave  bus,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0] SEED = W'(SIG_SEED);

  // Handshake: an issue transfers in a cycle where issue_valid_i and issue_ready_o are both high;
  // ready depends only on registered state, never on issue_valid_i.
  logic [1:0]       state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [LAT-1:0]   vpipe;
  logic [LAT-1:0]   vpipe_next;
  logic [W-1:0]     sig;
  logic [W-1:0]     res_data;
  logic             res_valid;
  logic             ready;
  logic             accept;
  logic             start_take;
  logic             capture;
  logic             last_capture;

  assign ready        = (state == S_RUN) && (issued < target);
  assign accept       = bus.issue_valid_i && ready;
  assign start_take   = bus.start_i && (state != S_RUN);
  assign capture      = vpipe[LAT-1];
  assign count_inc    = count + CNT_W'(1);
  assign last_capture = capture && (count_inc == target);

  generate
    if (LAT == 1) begin : g_vpipe_single
      assign vpipe_next = accept;
    end else begin : g_vpipe_shift
      assign vpipe_next = {vpipe[LAT-2:0], accept};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      target <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_take) begin
            target <= bus.num_i;
            state  <= (bus.num_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (last_capture) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset clears the delay line, so wrapper results still draining afterwards are never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe  <= '0;
      issued <= '0;
    end else if (start_take) begin
      vpipe  <= '0;
      issued <= '0;
    end else begin
      vpipe <= vpipe_next;
      if (accept) issued <= issued + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      sig       <= SEED;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= capture;
      if (start_take) begin
        count <= '0;
        sig   <= SEED;
      end else if (capture) begin
        count    <= count_inc;
        sig      <= {sig[W-2:0], sig[W-1]} ^ bus.dst_i;
        res_data <= bus.dst_i;
      end
    end
  end

  assign bus.issue_ready_o = ready;
  assign bus.res_valid_o   = res_valid;
  assign bus.res_data_o    = res_data;
  assign bus.sig_o         = sig;
  assign bus.count_o       = count;
  assign bus.busy_o        = (state == S_RUN);
  assign bus.done_o        = (state == S_DONE);
  assign state_dbg         = state;

endmodule

// File: tb/tb_uop_result_collector.sv
// Bench for uop_result_collector: a wrapper delay-line model feeds dst_i, a scoreboard queues the
// expected word and arrival cycle of every accepted issue, and scenario tasks check run-level results.
module tb_uop_result_collector;

  localparam int             W     = 64;
  localparam int             LAT   = 3;
  localparam int             CNT_W = 16;
  localparam logic [W-1:0]   SEED  = '0;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  logic [W-1:0] src;
  logic [W-1:0] wrap [LAT];

  uop_result_collector_if #(.W(W), .CNT_W(CNT_W)) bus ();

  uop_result_collector #(
    .W(W), .LAT(LAT), .CNT_W(CNT_W), .SIG_SEED(64'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [W-1:0]     exp_q[$];
  int               exp_cyc_q[$];
  logic [CNT_W-1:0] m_num    = '0;
  logic [CNT_W-1:0] m_issued = '0;
  logic             m_run    = 1'b0;
  logic [W-1:0]     m_sig    = SEED;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // wrapper model: src presented in cycle t appears on dst_i in cycle t+LAT
  always @(posedge clk) begin
    wrap[0] <= src;
    for (int i = 1; i < LAT; i++) wrap[i] <= wrap[i-1];
  end
  assign bus.dst_i = wrap[LAT-1];

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  // scoreboard: every res_valid pulse must match the oldest queued word at its exact cycle
  always @(negedge clk) begin
    if (bus.res_valid_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_capture cyc=%0d got_data=%h required=no_capture", cyc, bus.res_data_o);
      end else begin
        logic [W-1:0] d;
        int c;
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if (bus.res_data_o !== d || cyc !== c)
          $display("FAIL capture cyc=%0d data=%h required cyc=%0d data=%h", cyc, bus.res_data_o, c, d);
        else
          n_pass++;
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      n_checks++;
      $display("FAIL missing_capture cyc=%0d required_cyc=%0d data=%h", cyc, exp_cyc_q[0], exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  end

  // driver: one cycle of stimulus, checks issue_ready against the model
  task automatic drive(input logic st, input logic [CNT_W-1:0] n, input logic v, input logic [W-1:0] d);
    logic exp_rdy;
    bus.start_i       = st;
    bus.num_i         = n;
    bus.issue_valid_i = v;
    src               = d;
    exp_rdy = m_run && (m_issued < m_num);
    n_checks++;
    if (bus.issue_ready_o !== exp_rdy)
      $display("FAIL issue_ready cyc=%0d got=%b required=%b", cyc, bus.issue_ready_o, exp_rdy);
    else
      n_pass++;
    if (v && exp_rdy) begin
      m_issued++;
      exp_q.push_back(d);
      exp_cyc_q.push_back(cyc + LAT + 1);
      m_sig = {m_sig[W-2:0], m_sig[W-1]} ^ d;
    end
    @(posedge clk);
    #1;
    bus.start_i       = 1'b0;
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    drive(1'b1, n, 1'b0, rnd_word());
    m_num    = n;
    m_issued = '0;
    m_sig    = SEED;
    m_run    = (n != '0);
  endtask

  task automatic bubble();
    drive(1'b0, '0, 1'b0, rnd_word());
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus.done_o; i++) bubble();
    n_checks++;
    if (bus.done_o !== 1'b1) $display("FAIL done_timeout cyc=%0d got=%b required=1", cyc, bus.done_o);
    else n_pass++;
    bubble();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL pending_results got=%0d required=0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.res_valid_o !== 1'b0 || bus.res_data_o !== '0 || bus.sig_o !== SEED || bus.count_o !== '0)
      $display("FAIL reset_data got v=%b d=%h s=%h c=%0d required 0/0/%h/0",
               bus.res_valid_o, bus.res_data_o, bus.sig_o, bus.count_o, SEED);
    else n_pass++;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.issue_ready_o !== 1'b0)
      $display("FAIL reset_ctrl got busy=%b done=%b rdy=%b required 0/0/0", bus.busy_o, bus.done_o, bus.issue_ready_o);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // reset in the middle of a run, before the first result lands
    do_start(4);
    repeat (3) drive(1'b0, '0, 1'b1, rnd_word());
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    m_run = 1'b0; m_issued = '0; m_num = '0; m_sig = SEED;
    #1;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.issue_ready_o !== 1'b0 || bus.count_o !== '0)
      $display("FAIL midrun_reset got busy=%b rdy=%b cnt=%0d required 0/0/0", bus.busy_o, bus.issue_ready_o, bus.count_o);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) drive(1'b0, '0, 1'b1, rnd_word());
    n_checks++;
    if (bus.count_o !== '0 || bus.sig_o !== SEED || bus.done_o !== 1'b0 || bus.res_data_o !== '0)
      $display("FAIL post_reset got cnt=%0d sig=%h done=%b data=%h required 0/%h/0/0",
               bus.count_o, bus.sig_o, bus.done_o, bus.res_data_o, SEED);
    else n_pass++;
  endtask

  task automatic test_single();
    do_start(1);
    drive(1'b0, '0, 1'b1, 64'h1234);
    repeat (LAT - 1) bubble();
    n_checks++;
    if (bus.res_valid_o !== 1'b0 || bus.done_o !== 1'b0)
      $display("FAIL single_early got v=%b done=%b required 0/0", bus.res_valid_o, bus.done_o);
    else n_pass++;
    bubble();
    n_checks++;
    if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 64'h1234 || bus.sig_o !== 64'h1234 ||
        bus.count_o !== 16'd1 || bus.done_o !== 1'b1 || bus.busy_o !== 1'b0)
      $display("FAIL single got v=%b d=%h s=%h c=%0d done=%b busy=%b required 1/1234/1234/1/1/0",
               bus.res_valid_o, bus.res_data_o, bus.sig_o, bus.count_o, bus.done_o, bus.busy_o);
    else n_pass++;
    bubble();
    n_checks++;
    if (bus.res_valid_o !== 1'b0 || bus.done_o !== 1'b1 || exp_q.size() != 0)
      $display("FAIL single_after got v=%b done=%b pend=%0d required 0/1/0", bus.res_valid_o, bus.done_o, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_start(3);
    drive(1'b0, '0, 1'b1, 64'h1);
    drive(1'b0, '0, 1'b1, 64'h2);
    drive(1'b0, '0, 1'b1, 64'h4);
    repeat (LAT - 1) bubble();
    // start lands on the final capture edge and must be ignored
    drive(1'b1, 16'd7, 1'b0, rnd_word());
    n_checks++;
    if (bus.sig_o !== 64'h4 || bus.count_o !== 16'd3 || bus.res_data_o !== 64'h4 || bus.done_o !== 1'b1)
      $display("FAIL b2b got s=%h c=%0d d=%h done=%b required 4/3/4/1", bus.sig_o, bus.count_o, bus.res_data_o, bus.done_o);
    else n_pass++;
    bubble();
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b1 || bus.count_o !== 16'd3 || exp_q.size() != 0)
      $display("FAIL b2b_start_ignored got busy=%b done=%b c=%0d pend=%0d required 0/1/3/0",
               bus.busy_o, bus.done_o, bus.count_o, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_overissue();
    do_start(3);
    repeat (6) drive(1'b0, '0, 1'b1, rnd_word());
    wait_done(20);
    n_checks++;
    if (bus.count_o !== 16'd3 || bus.sig_o !== m_sig)
      $display("FAIL overissue got c=%0d s=%h required 3/%h", bus.count_o, bus.sig_o, m_sig);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    do_start(2);
    drive(1'b0, '0, 1'b1, rnd_word());
    repeat (2) bubble();
    drive(1'b0, '0, 1'b1, rnd_word());
    wait_done(20);
    n_checks++;
    if (bus.count_o !== 16'd2 || bus.sig_o !== m_sig)
      $display("FAIL bubbles got c=%0d s=%h required 2/%h", bus.count_o, bus.sig_o, m_sig);
    else n_pass++;
    do_start(0);
    n_checks++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.sig_o !== SEED || bus.count_o !== '0)
      $display("FAIL num_zero got done=%b busy=%b s=%h c=%0d required 1/0/%h/0",
               bus.done_o, bus.busy_o, bus.sig_o, bus.count_o, SEED);
    else n_pass++;
    drive(1'b0, '0, 1'b1, rnd_word());
    n_checks++;
    if (bus.count_o !== '0 || bus.done_o !== 1'b1)
      $display("FAIL num_zero_issue got c=%0d done=%b required 0/1", bus.count_o, bus.done_o);
    else n_pass++;
  endtask

  task automatic test_restart();
    do_start(3);
    drive(1'b0, '0, 1'b1, rnd_word());
    drive(1'b1, 16'd5, 1'b1, rnd_word());
    repeat (3) drive(1'b0, '0, 1'b1, rnd_word());
    wait_done(20);
    n_checks++;
    if (bus.count_o !== 16'd3 || bus.sig_o !== m_sig)
      $display("FAIL run_start_ignored got c=%0d s=%h required 3/%h", bus.count_o, bus.sig_o, m_sig);
    else n_pass++;
    do_start(1);
    n_checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.sig_o !== SEED || bus.count_o !== '0)
      $display("FAIL restart got done=%b busy=%b s=%h c=%0d required 0/1/%h/0",
               bus.done_o, bus.busy_o, bus.sig_o, bus.count_o, SEED);
    else n_pass++;
    drive(1'b0, '0, 1'b1, rnd_word());
    wait_done(20);
    n_checks++;
    if (bus.count_o !== 16'd1 || bus.sig_o !== m_sig)
      $display("FAIL restart_run got c=%0d s=%h required 1/%h", bus.count_o, bus.sig_o, m_sig);
    else n_pass++;
  endtask

  initial begin
    rst               = 1'b1;
    src               = '0;
    bus.start_i       = 1'b0;
    bus.num_i         = '0;
    bus.issue_valid_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overissue();
    test_bubbles();
    test_restart();
    repeat (LAT + 2) bubble();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
